// File: rtl/sync_upcount_timer_pkg.sv
// Shared definitions for the programmable-modulus up counter/timer:
// FSM state encodings and default counter/prescaler widths.
package sync_upcount_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_PRE_W = 4;

endpackage

// File: rtl/upcount_prescaler.sv
// Tick generator for sync_upcount_timer: one tick every prescale_div+1 enabled
// cycles. Built only when UPCOUNT_PRESCALER_EN is defined.
`ifdef UPCOUNT_PRESCALER_EN
module upcount_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             hold,
  input  logic [PRE_W-1:0] prescale_div,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt;

  assign tick = enable & ~clear & ~hold & (pre_cnt == prescale_div);

  // Phase restarts whenever the gate drops, so a re-enabled timer always
  // waits a full prescale period before its first tick.
  always_ff @(posedge clock) begin
    if (reset || clear || !enable) begin
      pre_cnt <= '0;
    end else if (!hold) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/sync_upcount_timer.sv
// Programmable-modulus up counter/timer with load, wrap/one-shot modes and a
// registered terminal-count pulse. Optional prescaler: UPCOUNT_PRESCALER_EN.
module sync_upcount_timer
  import sync_upcount_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
`ifdef UPCOUNT_PRESCALER_EN
  , parameter int PRE_W = DEF_PRE_W
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] modulus,
  input  logic             one_shot,
`ifdef UPCOUNT_PRESCALER_EN
  input  logic [PRE_W-1:0] prescale_div,
`endif
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             overflow,
  output logic             running,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;

`ifdef UPCOUNT_PRESCALER_EN
  upcount_prescaler #(
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clock        (clock),
    .reset        (reset),
    .clear        (load),
    .enable       (enable),
    .hold         (state_q == ST_DONE),
    .prescale_div (prescale_div),
    .tick         (tick)
  );
`else
  assign tick = enable & ~load & (state_q != ST_DONE);
`endif

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;

    if (load) begin
      count_d = load_value;
      ovf_d   = 1'b0;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (enable)  state_d = ST_RUN;
        ST_RUN:  if (!enable) state_d = ST_IDLE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase

      // Compare against the live modulus; a terminal one-shot tick taken on
      // the IDLE->RUN edge goes straight to DONE.
      if (tick) begin
        if (count_q == modulus) begin
          tc_d = 1'b1;
          if (one_shot) state_d = ST_DONE;
          else          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
          if (&count_q) ovf_d = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_out = count_q;
  assign tc        = tc_q;
  assign overflow  = ovf_q;
  assign running   = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);

endmodule
